comma_word_aligner: RTL and testbench
=====================================

# comma_word_aligner

Upstream neighbour of the 8b/10b decoder in the deserialization path. It receives a recovered serial bit stream one bit per clock and finds the comma (the K28.x 7-bit sequence) to set the 10-bit word boundary. It then presents aligned 10-bit symbols, with a word-valid strobe and the running disparity, to the decoder's `datain`/`dispin` inputs. A lock state machine manages acquisition and loss of alignment, using comma recurrence and the decoder's `code_err` feedback.

## Interface
- `LOCK_COMMAS`, default 3: aligned commas required, hunt hit included, to declare lock (≥2).
- `ERR_LIMIT`, default 4: consecutive errored words in LOCKED that force re-hunt (≥1).
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `sdin` input 1: serial data, first bit on the wire = bit `a`.
- `dec_code_err` input 1: decoder `code_err`, sampled only while `word_valid`=1.
- `dec_dispout` input 1: decoder `dispout`, sampled only while `word_valid`=1.
- `word_out` output 10: aligned symbol; bit 0 = a … bit 9 = j (decoder `datain` order).
- `word_valid` output 1: one-cycle strobe; `word_out` is valid.
- `rd_out` output 1: running disparity to decoder `dispin` (0 = RD−, 1 = RD+).
- `comma_det` output 1: `word_out` holds a comma; qualified by `word_valid`.
- `locked` output 1: high in LOCKED.

## Operation
- Shift register `sr[19:0]`: each clock `sr <= {sdin, sr[19:1]}`. The candidate word is `w = sr[19:10]`, with `w[0]` the oldest bit (a).
- Comma detection is combinational on `w`:
  - RD− comma: `w[6:0]=7'b1111100` (abcdefg = 0011111).
  - RD+ comma: `w[6:0]=7'b0000011` (abcdefg = 1100000).
  - `hit` = either pattern; `pol` = 1 for the RD+ form.
- Boundary counter `cnt` runs 0..9.
  - `boundary = (cnt==0)` in CHECK or LOCKED.
  - A realign event loads `cnt<=1`.
  - Otherwise `cnt` increments and wraps from 9 to 0.
- States: HUNT, CHECK, LOCKED. Reset state is HUNT.
- HUNT:
  - `hit` at any cycle is a realign event: `cnt<=1`, `good<=1`, emit `w`, `rd_out<=pol`.
  - If `LOCK_COMMAS`==1 the next state is LOCKED; otherwise CHECK.
- CHECK:
  - `boundary`: emit `w`.
    - `boundary & hit`: `good++`; on reaching `LOCK_COMMAS`, go to LOCKED and clear `errs`.
    - `boundary & !hit`: stay in CHECK with no change to `good`.
  - `!boundary & hit`: misaligned comma, handled as a realign event exactly as in HUNT (`good<=1`).
  - `dec_code_err` in CHECK: `good<=0`, return to HUNT.
- LOCKED:
  - `boundary`: emit `w`.
  - Non-boundary commas are ignored.
  - On each `word_valid` cycle: `dec_code_err=1` gives `errs++`; `dec_code_err=0` gives `errs<=0`.
  - Reaching `ERR_LIMIT` sends the state to HUNT; `locked` falls on that edge.
- Disparity:
  - On every `word_valid` cycle, `rd_out <= dec_dispout`.
  - Exception: a realign-emit coinciding with `word_valid` loads `pol`. A realign has priority over the dispout update.
- Simultaneous events:
  - An `ERR_LIMIT` trip and a `hit` in the same cycle go to HUNT; the hit is not used. Hunting starts next cycle.
  - In CHECK, a `word_valid` error and a misaligned hit in the same cycle go to HUNT; the error has priority.
- Counter widths: `good` is `$clog2(LOCK_COMMAS+1)` bits and `errs` is `$clog2(ERR_LIMIT+1)` bits. Both saturate and never wrap.

## Timing
- "Emit" means registering at the next edge: `word_out<=w`, `word_valid<=1`, `comma_det<=hit`. `word_valid` is 0 on every other cycle.
- Latency: bit j of a word is sampled at edge N, and `word_valid`/`word_out` are high after edge N+1.
- Once aligned, `word_valid` pulses exactly every 10 clocks.
- The decoder path is combinational. `dec_*` inputs are consumed in the same cycle that `word_valid`=1.
- `rd_out` presented with a word is the disparity before that word.
- Reset values, asynchronous and immediate:
  - `sr`=0, `cnt`=0, `good`=0, `errs`=0, state HUNT.
  - `word_out`=10'h000, `word_valid`=0, `rd_out`=0, `comma_det`=0, `locked`=0.
- Reset mid-word discards the partial word. After release, a realign needs at least 10 `sdin` bits (7-bit comma in `w[6:0]`).

## Structure
- Package `enc8b10b_pkg` holds:
  - state enum `align_state_t` {HUNT, CHECK, LOCKED};
  - constants `COMMA_P=7'b1111100`, `COMMA_N=7'b0000011`, `WORD_W=10`.
- One natural sub-module, `comma_detect`: combinational, `w[6:0]` → `hit`, `pol`. It is shared with the future parallel aligner.
- The decoder is not instantiated here. The top level wires `word_out`→`datain`, `rd_out`→`dispin`, and `code_err`/`dispout` back.

## Test plan
- **Acquisition:**
  - Stimulus: K28.5 RD− (0011111010) then RD+ (1100000101) alternating, preceded by 3 random bits.
  - Required: `word_valid` every 10 clocks; `word_out`=10'h17C, `rd_out`=0 on the first word; `locked`=1 after the 3rd aligned comma.
- **Error loss:**
  - Stimulus: in LOCKED, force `dec_code_err`=1 on 4 consecutive `word_valid` cycles.
  - Required: `locked`=0 after the 4th; state HUNT.
- **Error recovery:**
  - Stimulus: in LOCKED, apply 3 errors, 1 clean word, then 3 errors.
  - Required: `locked` stays 1.
- **Misaligned comma in CHECK:**
  - Stimulus: after the first comma, insert 4 extra bits and resend the comma.
  - Required: `cnt` realigns to the new comma and `good` restarts at 1; lock follows 2 further aligned commas.
- **Reset mid-operation:**
  - Stimulus: assert `rst` asynchronously mid-word while LOCKED.
  - Required: all outputs go to reset values immediately, with no `word_valid` until a new comma.
- **Disparity:**
  - Stimulus: D21.5 words (balanced) after an RD+ comma, with the decoder model returning `dispout`.
  - Required: `rd_out` follows `dispout` on each word.

Source files
------------

// File: rtl/enc8b10b_pkg.sv
// Shared types and constants for the 8b/10b deserialization path.
// Used by the serial comma aligner and by the comma detector it shares with the parallel aligner.
package enc8b10b_pkg;

  localparam int WORD_W  = 10;
  localparam int COMMA_W = 7;

  // Comma sequences as seen in w[6:0] (w[0] = bit a, first on the wire).
  localparam logic [COMMA_W-1:0] COMMA_P = 7'b1111100;  // abcdefg = 0011111, RD- form
  localparam logic [COMMA_W-1:0] COMMA_N = 7'b0000011;  // abcdefg = 1100000, RD+ form

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } align_state_t;

endpackage

// File: rtl/comma_detect.sv
// Combinational K28.x comma detector on the first seven bits of a candidate word.
// pol reports which disparity form matched (1 = RD+ form).
module comma_detect
  import enc8b10b_pkg::*;
(
  input  logic [COMMA_W-1:0] w7,
  output logic               hit,
  output logic               pol
);

  logic hit_neg;
  logic hit_pos;

  assign hit_neg = (w7 == COMMA_P);
  assign hit_pos = (w7 == COMMA_N);
  assign hit     = hit_neg | hit_pos;
  assign pol     = hit_pos;

endmodule

// File: rtl/comma_word_aligner.sv
// Serial-to-word aligner: finds the comma in a 1-bit/clock stream, frames 10-bit symbols and
// tracks lock using comma recurrence and the downstream decoder's code_err/dispout feedback.
module comma_word_aligner
  import enc8b10b_pkg::*;
#(
  parameter int LOCK_COMMAS = 3,
  parameter int ERR_LIMIT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdin,
  input  logic              dec_code_err,
  input  logic              dec_dispout,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              rd_out,
  output logic              comma_det,
  output logic              locked
);

  localparam int GW = $clog2(LOCK_COMMAS + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam logic [GW-1:0] GOOD_TGT = GW'(LOCK_COMMAS);
  localparam logic [EW-1:0] ERR_TGT  = EW'(ERR_LIMIT);
  localparam logic [3:0]    CNT_LAST = 4'(WORD_W - 1);

  // Only the upper half of the 20-bit shift window ever forms w, so just that half is stored.
  logic [WORD_W-1:0] sr_reg;

  align_state_t      state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [GW-1:0]     good_reg, good_next;
  logic [EW-1:0]     errs_reg, errs_next;
  logic [WORD_W-1:0] word_reg, word_next;
  logic              valid_reg, valid_next;
  logic              rd_reg, rd_next;
  logic              comma_reg, comma_next;

  logic [WORD_W-1:0] w;
  logic              hit;
  logic              pol;
  logic              boundary;
  logic              word_err;
  logic              realign;
  logic              emit;
  logic [GW-1:0]     good_inc;
  logic [EW-1:0]     errs_inc;

  assign w = sr_reg;

  comma_detect u_comma_detect (
    .w7  (w[COMMA_W-1:0]),
    .hit (hit),
    .pol (pol)
  );

  assign boundary = (state_reg != HUNT) && (cnt_reg == 4'd0);
  assign word_err = valid_reg && dec_code_err;
  assign good_inc = (good_reg == GOOD_TGT) ? good_reg : good_reg + GW'(1);
  assign errs_inc = (errs_reg == ERR_TGT) ? errs_reg : errs_reg + EW'(1);

  always_comb begin
    state_next = state_reg;
    good_next  = good_reg;
    errs_next  = errs_reg;
    cnt_next   = (cnt_reg == CNT_LAST) ? 4'd0 : cnt_reg + 4'd1;
    realign    = 1'b0;
    emit       = 1'b0;

    unique case (state_reg)
      HUNT: begin
        if (hit) realign = 1'b1;
      end

      CHECK: begin
        // A decoder error outranks a misaligned comma arriving in the same cycle.
        if (word_err) begin
          good_next  = '0;
          state_next = HUNT;
        end else if (boundary) begin
          emit = 1'b1;
          if (hit) begin
            good_next = good_inc;
            if (good_inc == GOOD_TGT) begin
              state_next = LOCKED;
              errs_next  = '0;
            end
          end
        end else if (hit) begin
          realign = 1'b1;
        end
      end

      LOCKED: begin
        if (valid_reg) errs_next = dec_code_err ? errs_inc : '0;
        // On an error trip any coincident comma is dropped; hunting restarts next cycle.
        if (word_err && (errs_inc == ERR_TGT)) begin
          state_next = HUNT;
        end else if (boundary) begin
          emit = 1'b1;
        end
      end

      default: state_next = HUNT;
    endcase

    if (realign) begin
      emit      = 1'b1;
      cnt_next  = 4'd1;
      good_next = GW'(1);
      if (LOCK_COMMAS == 1) begin
        state_next = LOCKED;
        errs_next  = '0;
      end else begin
        state_next = CHECK;
      end
    end

    word_next  = emit ? w : word_reg;
    valid_next = emit;
    comma_next = emit && hit;

    // A fresh alignment restarts disparity from the comma's own form.
    rd_next = rd_reg;
    if (realign) rd_next = pol;
    else if (valid_reg) rd_next = dec_dispout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_reg    <= '0;
      state_reg <= HUNT;
      cnt_reg   <= 4'd0;
      good_reg  <= '0;
      errs_reg  <= '0;
      word_reg  <= '0;
      valid_reg <= 1'b0;
      rd_reg    <= 1'b0;
      comma_reg <= 1'b0;
    end else begin
      sr_reg    <= {sdin, sr_reg[WORD_W-1:1]};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      good_reg  <= good_next;
      errs_reg  <= errs_next;
      word_reg  <= word_next;
      valid_reg <= valid_next;
      rd_reg    <= rd_next;
      comma_reg <= comma_next;
    end
  end

  assign word_out   = word_reg;
  assign word_valid = valid_reg;
  assign rd_out     = rd_reg;
  assign comma_det  = comma_reg;
  assign locked     = (state_reg == LOCKED);

endmodule

// File: tb/tb_comma_word_aligner.sv
// Scoreboard bench for comma_word_aligner: directed bit streams, expected words queued at send time,
// a negedge monitor pops and compares on every word_valid, and a small decoder model closes the loop.
module tb_comma_word_aligner;

  logic       clk = 1'b0;
  logic       rst;
  logic       sdin;
  logic       dec_code_err;
  logic       dec_dispout;
  logic [9:0] word_out;
  logic       word_valid;
  logic       rd_out;
  logic       comma_det;
  logic       locked;

  always #5 clk = ~clk;

  comma_word_aligner #(.LOCK_COMMAS(3), .ERR_LIMIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sdin         (sdin),
    .dec_code_err (dec_code_err),
    .dec_dispout  (dec_dispout),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .rd_out       (rd_out),
    .comma_det    (comma_det),
    .locked       (locked)
  );

  localparam logic [9:0] K_NEG = 10'h17C;  // K28.5 RD-  0011111010
  localparam logic [9:0] K_POS = 10'h283;  // K28.5 RD+  1100000101
  localparam logic [9:0] D215  = 10'h155;  // D21.5      1010101010
  localparam logic [9:0] BAD   = 10'h3FF;  // corrupted symbol, flagged by the decoder model

  // Decoder stand-in: flags BAD, otherwise derives dispout from the symbol's ones count.
  always_comb begin
    dec_code_err = word_valid && (word_out == BAD);
    if (word_out == BAD)                dec_dispout = rd_out;
    else if ($countones(word_out) > 5)  dec_dispout = 1'b1;
    else if ($countones(word_out) < 5)  dec_dispout = 1'b0;
    else                                dec_dispout = rd_out;
  end

  typedef struct {
    logic [9:0] word;
    logic       rd;
    logic       comma;
    logic       lck;
    logic       lck_after;
    logic       gap_chk;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cycle       = 0;
  int   last_cyc    = -100;
  int   word_idx    = 0;
  bit   pend        = 1'b0;
  logic pend_lock   = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one line per emitted word, compares against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("locked_after_word", 32'(locked), 32'(pend_lock));
        pend = 1'b0;
      end
      if (word_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word_valid", 32'(word_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          word_idx++;
          $display("word %0d: word_out=%03h rd_out=%0d comma_det=%0d locked=%0d gap=%0d",
                   word_idx, word_out, rd_out, comma_det, locked, cycle - last_cyc);
          check("word_out", 32'(word_out), 32'(e.word));
          check("rd_out", 32'(rd_out), 32'(e.rd));
          check("comma_det", 32'(comma_det), 32'(e.comma));
          check("locked", 32'(locked), 32'(e.lck));
          if (e.gap_chk) check("valid_period", 32'(cycle - last_cyc), 32'd10);
          pend      = 1'b1;
          pend_lock = e.lck_after;
        end
        last_cyc = cycle;
      end
    end
  end

  task automatic send_bits(input logic [9:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 sdin = bits[i];
    end
  endtask

  task automatic send_word(input logic [9:0] word, input bit push, input logic rd, input logic comma,
                           input logic lck, input logic lck_after, input logic gap);
    exp_t e;
    if (push) begin
      e.word = word; e.rd = rd; e.comma = comma;
      e.lck = lck; e.lck_after = lck_after; e.gap_chk = gap;
      exp_q.push_back(e);
    end
    send_bits(word, 10);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_word_out"}, 32'(word_out), 32'd0);
    check({tag, "_word_valid"}, 32'(word_valid), 32'd0);
    check({tag, "_rd_out"}, 32'(rd_out), 32'd0);
    check({tag, "_comma_det"}, 32'(comma_det), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
  endtask

  initial begin
    logic [9:0] lead;
    exp_t       g;
    int         waited;
    rst  = 1'b0;
    sdin = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Acquisition: 3 arbitrary lead bits, then alternating K28.5; lock on the third comma.
    lead = 10'($urandom_range(0, 7));
    send_bits(lead, 3);
    //          word   push rd    comma lck   after gap
    send_word(K_NEG, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(K_POS, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    send_word(K_NEG, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    send_word(K_POS, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    // Disparity: balanced D21.5 keeps RD, commas flip it.
    send_word(D215,  1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_word(D215,  1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_word(K_NEG, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    send_word(D215,  1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    send_word(D215,  1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    send_word(K_POS, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    // Error recovery: 3 errors, a clean word, 3 errors -> lock held.
    for (int i = 0; i < 3; i++) send_word(BAD, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_word(D215, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send_word(BAD, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_word(D215, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Error loss: the 4th consecutive error drops lock right after its word.
    for (int i = 0; i < 3; i++) send_word(BAD, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_word(BAD, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Re-hunt, then a comma shifted by 4 bits while in CHECK.
    send_word(K_NEG, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    g.word = 10'h035; g.rd = 1'b1; g.comma = 1'b0; g.lck = 1'b0; g.lck_after = 1'b0; g.gap_chk = 1'b1;
    exp_q.push_back(g);  // boundary word straddling the 4 extra bits and the next comma
    send_bits(10'b0000000101, 4);
    send_word(K_POS, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(K_NEG, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    send_word(K_POS, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    send_word(K_NEG, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a word while locked.
    send_bits(D215, 5);
    #3 rst = 1'b1;
    #1 check_reset_outputs("midreset");
    check("midreset_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    send_word(D215,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(K_NEG, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Drain: every queued word must have been presented within a bounded wait.
    waited = 0;
    while ((exp_q.size() != 0 || pend) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
